// File: rtl/q215_requant.sv
// Q2.15 -> 8-bit requantizer: optional round-half-up, per-sample format select,
// clamp with saturation flag, two-stage valid/ready pipeline and saturation counter.
module q215_requant #(
  parameter bit ROUND = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_data,
  input  logic [1:0]  in_fmt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sat,
  input  logic        sat_clr,
  output logic [15:0] sat_count
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [17:0] sum;
    logic [1:0]  fmt;
  } s1_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sat;
  } s2_t;

  // Reserved format 11 falls through to the Q2.6 shift.
  function automatic logic [3:0] shift_of(input logic [1:0] fmt);
    case (fmt)
      2'b00:   return 4'd8;
      2'b10:   return 4'd7;
      default: return 4'd9;
    endcase
  endfunction

  logic [STAGES:1] vld_pipe;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic            s1_load, s2_load;
  logic [3:0]      in_shift, s1_shift;
  logic [17:0]     rnd_add;
  logic [10:0]     quot;

  assign s2_load  = !vld_pipe[2] || out_ready;
  assign s1_load  = !vld_pipe[1] || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    in_shift = shift_of(in_fmt);
    rnd_add  = ROUND ? (18'd1 << (in_shift - 4'd1)) : 18'd0;
    s1_d.sum = {1'b0, in_data} + rnd_add;
    s1_d.fmt = in_fmt;
  end

  // 18-bit sum shifted by at least 7 leaves at most 11 significant bits.
  always_comb begin
    s1_shift  = shift_of(s1_q.fmt);
    quot      = 11'(s1_q.sum >> s1_shift);
    s2_d.sat  = (quot > 11'd255);
    s2_d.data = s2_d.sat ? 8'hFF : quot[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_data  = s2_q.data;
  assign out_sat   = s2_q.sat;

  // Clear wins over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n || sat_clr)
      sat_count <= '0;
    else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_q215_requant.sv
// Bench for q215_requant: a rounding and a truncating instance share stimulus and
// are checked against an arithmetic reference model through expected/observed queues.
module tb_q215_requant;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready, sat_clr;
  logic [16:0] in_data;
  logic [1:0]  in_fmt;
  logic        in_ready_r, out_valid_r, out_sat_r, in_ready_t, out_valid_t, out_sat_t;
  logic [7:0]  out_data_r, out_data_t;
  logic [15:0] sat_count_r, sat_count_t;

  always #5 clk = ~clk;

  q215_requant #(.ROUND(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .in_fmt(in_fmt), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .out_sat(out_sat_r), .sat_clr(sat_clr), .sat_count(sat_count_r));

  q215_requant #(.ROUND(1'b0)) dut_t (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_data(in_data), .in_fmt(in_fmt), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_data(out_data_t), .out_sat(out_sat_t), .sat_clr(sat_clr), .sat_count(sat_count_t));

  int n_cmp = 0, n_err = 0;
  int exp_r[$], exp_t[$], obs_r[$], obs_t[$];

  // Encoded result: sat*256 + data, so a clamped output is 511.
  function automatic int model(input int x, input int f, input int rnd);
    int sh, s, q;
    sh = (f == 0) ? 8 : (f == 2) ? 7 : 9;
    s  = x + ((rnd != 0) ? 2 ** (sh - 1) : 0);
    q  = s / (2 ** sh);
    return (q > 255) ? 511 : q;
  endfunction

  function automatic int count_sat(input int q[$]);
    int n = 0;
    foreach (q[i]) if (q[i] >= 256) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_ready) begin
      if (out_valid_r) obs_r.push_back(int'({out_sat_r, out_data_r}));
      if (out_valid_t) obs_t.push_back(int'({out_sat_t, out_data_t}));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(input int x, input int f);
    in_valid = 1'b1; in_data = 17'(x); in_fmt = 2'(f);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input int x, input int f);
    exp_r.push_back(model(x, f, 1));
    exp_t.push_back(model(x, f, 0));
  endtask

  task automatic send(input int x, input int f);
    logic acc = 1'b0;
    present(x, f);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = in_ready_r; tick();
    end
    if (acc) push_exp(x, f);
    else begin n_cmp++; n_err++; $display("FAIL send_timeout data %h never accepted", x); end
  endtask

  task automatic settle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (obs_r.size() >= exp_r.size() && obs_t.size() >= exp_t.size()) break;
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; idle(); sat_clr = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    present(17'h1FFFF, 0);
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (out_valid_r !== 1'b0 || out_valid_t !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b/%b want 0", out_valid_r, out_valid_t); end
    n_cmp++; if (out_data_r !== 8'h00 || out_sat_r !== 1'b0) begin n_err++; $display("FAIL reset_data got %h/%b want 00/0", out_data_r, out_sat_r); end
    n_cmp++; if (sat_count_r !== 16'h0 || sat_count_t !== 16'h0) begin n_err++; $display("FAIL reset_count got %h/%h want 0", sat_count_r, sat_count_t); end
    tick();
    reset_n = 1'b1; idle(); out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready_r !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready_r); end
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      n_cmp++; if (out_valid_r !== 1'b0) begin n_err++; $display("FAIL reset_no_accept cycle %0d got out_valid %b want 0", i, out_valid_r); end
    end
    tick();
    obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_rounding();
    int a, e;
    out_ready = 1'b1;
    send(17'h00180, 0);
    idle();
    @(negedge clk);
    n_cmp++; if (out_valid_r !== 1'b0) begin n_err++; $display("FAIL latency_early got out_valid %b want 0", out_valid_r); end
    tick(); @(negedge clk);
    n_cmp++; if (out_valid_r !== 1'b1 || out_data_r !== 8'h02 || out_sat_r !== 1'b0)
      begin n_err++; $display("FAIL latency_due got v%b %h s%b want v1 02 s0", out_valid_r, out_data_r, out_sat_r); end
    tick();
    send(17'h0017F, 0);
    send(17'h00040, 2);
    send(17'h001FF, 0);
    idle();
    settle(40);
    n_cmp++; if (obs_r.size() != exp_r.size() || obs_t.size() != exp_t.size()) begin n_err++; $display("FAIL rounding_count got %0d/%0d want %0d/%0d", obs_r.size(), obs_t.size(), exp_r.size(), exp_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL rounding_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL truncate_t got %h want %h", a, e); end end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_back_to_back();
    int a, e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      present($urandom_range(0, 17'h1FFFF), $urandom_range(0, 3));
      @(negedge clk);
      n_cmp++; if (in_ready_r !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, in_ready_r); end
      n_cmp++; if (out_valid_r !== 1'(i >= 2)) begin n_err++; $display("FAIL b2b_out_valid cycle %0d got %b want %b", i, out_valid_r, i >= 2); end
      if (in_ready_r) push_exp(int'(in_data), int'(in_fmt));
      tick();
    end
    idle();
    settle(40);
    n_cmp++; if (obs_r.size() != exp_r.size() || obs_t.size() != exp_t.size()) begin n_err++; $display("FAIL b2b_count got %0d/%0d want %0d/%0d", obs_r.size(), obs_t.size(), exp_r.size(), exp_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL b2b_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL b2b_t got %h want %h", a, e); end end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_backpressure();
    int smp[5], fmt[5];
    int acc_n = 0, a, e;
    foreach (smp[i]) begin smp[i] = $urandom_range(0, 17'h1FFFF); fmt[i] = $urandom_range(0, 3); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      present(smp[acc_n], fmt[acc_n]);
      @(negedge clk);
      n_cmp++; if (in_ready_r !== 1'(acc_n < 2)) begin n_err++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready_r, acc_n < 2); end
      if (c >= 2) begin
        n_cmp++; if (out_valid_r !== 1'b1 || int'({out_sat_r, out_data_r}) !== model(smp[0], fmt[0], 1))
          begin n_err++; $display("FAIL bp_hold cycle %0d got v%b %h want v1 %h", c, out_valid_r, {out_sat_r, out_data_r}, model(smp[0], fmt[0], 1)); end
      end
      if (in_ready_r) begin push_exp(smp[acc_n], fmt[acc_n]); acc_n++; end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && acc_n < 5; c++) begin
      present(smp[acc_n], fmt[acc_n]);
      @(negedge clk);
      n_cmp++; if (in_ready_r !== 1'b1) begin n_err++; $display("FAIL bp_drain_in_ready cycle %0d got %b want 1", c, in_ready_r); end
      if (in_ready_r) begin push_exp(smp[acc_n], fmt[acc_n]); acc_n++; end
      tick();
    end
    idle();
    settle(40);
    n_cmp++; if (obs_r.size() != 5 || obs_t.size() != 5) begin n_err++; $display("FAIL bp_count got %0d/%0d want 5", obs_r.size(), obs_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL bp_order_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL bp_order_t got %h want %h", a, e); end end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_saturation();
    int a, e, ns_r, ns_t;
    do_reset();
    out_ready = 1'b1;
    send(17'h1FFFF, 0);
    send(17'h07FC0, 2);
    send(17'h1FF00, 1);
    send(17'h1FE00, 1);
    idle();
    ns_r = count_sat(exp_r); ns_t = count_sat(exp_t);
    settle(40);
    tick();
    n_cmp++; if (obs_r.size() != exp_r.size() || obs_t.size() != exp_t.size()) begin n_err++; $display("FAIL sat_count_out got %0d/%0d want %0d/%0d", obs_r.size(), obs_t.size(), exp_r.size(), exp_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL sat_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL sat_t got %h want %h", a, e); end end
    n_cmp++; if (int'(sat_count_r) !== ns_r || int'(sat_count_t) !== ns_t) begin n_err++; $display("FAIL sat_counter got %0d/%0d want %0d/%0d", sat_count_r, sat_count_t, ns_r, ns_t); end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_fmt();
    int a, e;
    out_ready = 1'b1;
    send(17'h10000, 0);
    send(17'h10000, 2);
    send(17'h10000, 3);
    present(17'h10000, 0);
    idle();
    settle(40);
    n_cmp++; if (obs_r.size() != 3 || obs_t.size() != 3) begin n_err++; $display("FAIL fmt_count got %0d/%0d want 3", obs_r.size(), obs_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL fmt_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL fmt_t got %h want %h", a, e); end end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_trunc_clear();
    int a, e;
    logic seen = 1'b0;
    out_ready = 1'b0;
    send(17'h1FFFF, 0);
    idle();
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = out_valid_r; tick(); end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL clr_setup got out_valid 0 want 1"); end
    sat_clr = 1'b1; out_ready = 1'b1;
    tick();
    sat_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (sat_count_r !== 16'h0 || sat_count_t !== 16'h0) begin n_err++; $display("FAIL clr_priority got %h/%h want 0000", sat_count_r, sat_count_t); end
    settle(20);
    n_cmp++; if (obs_r.size() != 1 || obs_t.size() != 1) begin n_err++; $display("FAIL clr_count got %0d/%0d want 1", obs_r.size(), obs_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL clr_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL clr_t got %h want %h", a, e); end end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_random();
    int a, e, ns_r, ns_t, accepted = 0;
    do_reset();
    for (int c = 0; c < 3000 && accepted < 200; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0)
        present($urandom_range(0, 1) ? $urandom_range(0, 17'h1FFFF) : $urandom_range(0, 17'h07FFF), $urandom_range(0, 3));
      else idle();
      @(negedge clk);
      if (in_valid && in_ready_r) begin push_exp(int'(in_data), int'(in_fmt)); accepted++; end
      tick();
    end
    idle(); out_ready = 1'b1;
    ns_r = count_sat(exp_r); ns_t = count_sat(exp_t);
    settle(50);
    tick();
    n_cmp++; if (obs_r.size() != exp_r.size() || obs_t.size() != exp_t.size()) begin n_err++; $display("FAIL rand_count got %0d/%0d want %0d/%0d", obs_r.size(), obs_t.size(), exp_r.size(), exp_t.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin a = obs_r.pop_front(); e = exp_r.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL rand_r got %h want %h", a, e); end end
    while (exp_t.size() > 0 && obs_t.size() > 0) begin a = obs_t.pop_front(); e = exp_t.pop_front(); n_cmp++; if (a !== e) begin n_err++; $display("FAIL rand_t got %h want %h", a, e); end end
    n_cmp++; if (int'(sat_count_r) !== ns_r || int'(sat_count_t) !== ns_t) begin n_err++; $display("FAIL rand_sat_counter got %0d/%0d want %0d/%0d", sat_count_r, sat_count_t, ns_r, ns_t); end
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(17'h1FFFF, 0);
    send(17'h00180, 0);
    idle();
    @(negedge clk);
    n_cmp++; if (out_valid_r !== 1'b1 || in_ready_r !== 1'b0) begin n_err++; $display("FAIL mid_full got v%b rdy%b want v1 rdy0", out_valid_r, in_ready_r); end
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (out_valid_r !== 1'b0 || out_valid_t !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b/%b want 0", out_valid_r, out_valid_t); end
    n_cmp++; if (sat_count_r !== 16'h0 || out_data_r !== 8'h00 || out_sat_r !== 1'b0) begin n_err++; $display("FAIL mid_state got cnt %h data %h sat %b want 0", sat_count_r, out_data_r, out_sat_r); end
    tick();
    reset_n = 1'b1; out_ready = 1'b1;
    exp_r.delete(); exp_t.delete(); obs_r.delete(); obs_t.delete();
    @(negedge clk);
    n_cmp++; if (in_ready_r !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %b want 1", in_ready_r); end
    repeat (6) tick();
    n_cmp++; if (obs_r.size() != 0 || obs_t.size() != 0) begin n_err++; $display("FAIL mid_stale got %0d/%0d outputs want 0", obs_r.size(), obs_t.size()); end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_fmt = '0; out_ready = 1'b0; sat_clr = 1'b0;
    test_reset();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_fmt();
    test_trunc_clear();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
